// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: operation codes, FSM state
// encoding and default datapath sizes.
package shift_sequencer_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int SHAMT_W_DEF = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit combinational shifter. SRA keeps the current MSB, which is the
// latched operand's sign bit because every arithmetic step preserves it.
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] value,
  input  op_e               op,
  output logic [DATA_W-1:0] shifted
);

  // Select the single-bit shift for the requested operation.
  always_comb begin
    shifted = value;
    case (op)
      OP_SLL:  shifted = {value[DATA_W-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, value[DATA_W-1:1]};
      OP_SRA:  shifted = {value[DATA_W-1], value[DATA_W-1:1]};
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-less shifter: one bit per clock, counted down from the
// latched shift amount. Busy/Done/Result all come straight from flops, so
// Start never reaches an output combinationally.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [1:0]         Op,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic [DATA_W-1:0]  DataIn,
  input  logic               Abort,
  output logic               Busy,
  output logic               Done,
  output logic [DATA_W-1:0]  Result
);

  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [DATA_W-1:0]  DATA_ZERO = {DATA_W{1'b0}};

  state_e              state_r;
  state_e              state_nxt_s;
  op_e                 op_r;
  logic [SHAMT_W-1:0]  cnt_r;
  logic [DATA_W-1:0]   work_r;
  logic [DATA_W-1:0]   result_r;
  logic [DATA_W-1:0]   step_s;
  logic                busy_r;
  logic                done_r;
  logic                busy_nxt_s;
  logic                done_nxt_s;
  logic                accept_s;
  logic                bypass_s;
  logic                last_step_s;

  shift_step #(
    .DATA_W (DATA_W)
  ) u_shift_step (
    .value   (work_r),
    .op      (op_r),
    .shifted (step_s)
  );

  // Request qualification: acceptance window and zero-work bypass detection.
  always_comb begin
    accept_s    = 1'b0;
    bypass_s    = 1'b0;
    last_step_s = (cnt_r == CNT_ONE);
    if ((state_r == IDLE) || (state_r == DONE)) begin
      accept_s = Start;
    end else begin
      accept_s = 1'b0;
    end
    if ((Shamt == CNT_ZERO) || (Op == OP_RSVD)) begin
      bypass_s = 1'b1;
    end else begin
      bypass_s = 1'b0;
    end
  end

  // Next-state logic; Abort takes priority over completion and new Starts.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (Start) begin
          state_nxt_s = bypass_s ? DONE : SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (Abort) begin
          state_nxt_s = IDLE;
        end else if (last_step_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode of the upcoming state so Busy/Done can be registered.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    if (state_nxt_s == SHIFT) begin
      busy_nxt_s = 1'b1;
    end else if (state_nxt_s == DONE) begin
      done_nxt_s = 1'b1;
    end else begin
      busy_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
    end
  end

  // State register with registered status flags.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Datapath: operand capture, per-cycle shift/count, result update.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_r     <= OP_SLL;
      cnt_r    <= CNT_ZERO;
      work_r   <= DATA_ZERO;
      result_r <= DATA_ZERO;
    end else if (accept_s) begin
      op_r   <= op_e'(Op);
      cnt_r  <= Shamt;
      work_r <= DataIn;
      if (bypass_s) begin
        result_r <= DataIn;
      end else begin
        result_r <= result_r;
      end
    end else if (state_r == SHIFT) begin
      if (Abort) begin
        cnt_r    <= CNT_ZERO;
        work_r   <= DATA_ZERO;
        result_r <= DATA_ZERO;
      end else begin
        cnt_r  <= cnt_r - CNT_ONE;
        work_r <= step_s;
        if (last_step_s) begin
          result_r <= step_s;
        end else begin
          result_r <= result_r;
        end
      end
    end else begin
      cnt_r    <= cnt_r;
      work_r   <= work_r;
      result_r <= result_r;
    end
  end

  assign Busy   = busy_r;
  assign Done   = done_r;
  assign Result = result_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus random
// operations compared against an arithmetic reference model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .Clk    (clk),
    .Rst_n  (rst_n),
    .Start  (start),
    .Op     (op),
    .Shamt  (shamt),
    .DataIn (data_in),
    .Abort  (abort),
    .Busy   (busy),
    .Done   (done),
    .Result (result)
  );

  // Reference: plain shift operators on the full operand.
  function automatic logic [31:0] ref_shift(logic [1:0] o, logic [4:0] s, logic [31:0] d);
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 32'($signed(d) >>> s);
      default: return d;
    endcase
  endfunction

  // Reference: number of Busy cycles before Done (Done index after accept).
  function automatic int ref_cycles(logic [1:0] o, logic [4:0] s);
    return (o == 2'b11) ? 0 : int'(s);
  endfunction

  // Issue one request and observe it; n=0 is the cycle right after acceptance.
  task automatic run_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d,
                        input bit scramble, input bit with_abort,
                        output int done_at, output int busy_cnt, output logic [31:0] res);
    @(negedge clk);
    start = 1'b1; op = o; shamt = s; data_in = d; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    if (scramble) begin
      op = 2'($urandom); shamt = 5'($urandom); data_in = $urandom;
    end
    done_at = -1; busy_cnt = 0; res = 'x;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_at = n; res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; shamt = 5'd0; data_in = 32'h0; abort = 1'b0;
    #12;
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_sll_basic();
    int d_at, b_cnt; logic [31:0] r;
    run_op(2'b00, 5'd4, 32'h1, 1'b1, 1'b0, d_at, b_cnt, r);
    total++; if (d_at !== 4)       begin bad++; $display("FAIL sll4_latency: got %0d want 4", d_at); end
    total++; if (b_cnt !== 4)      begin bad++; $display("FAIL sll4_busy: got %0d want 4", b_cnt); end
    total++; if (r !== 32'h10)     begin bad++; $display("FAIL sll4_result: got %h want 00000010", r); end
  endtask

  task automatic test_sra_srl_31();
    int d_at, b_cnt; logic [31:0] r;
    run_op(2'b10, 5'd31, 32'h8000_0000, 1'b0, 1'b0, d_at, b_cnt, r);
    total++; if (d_at !== 31)         begin bad++; $display("FAIL sra31_latency: got %0d want 31", d_at); end
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sra31_result: got %h want ffffffff", r); end
    run_op(2'b01, 5'd31, 32'h8000_0000, 1'b0, 1'b0, d_at, b_cnt, r);
    total++; if (d_at !== 31)         begin bad++; $display("FAIL srl31_latency: got %0d want 31", d_at); end
    total++; if (r !== 32'h1)         begin bad++; $display("FAIL srl31_result: got %h want 00000001", r); end
  endtask

  task automatic test_bypass();
    int d_at, b_cnt; logic [31:0] r;
    for (int o = 0; o < 5; o++) begin
      // o==4 stands for the reserved opcode with a nonzero amount
      run_op((o == 4) ? 2'b11 : 2'(o), (o == 4) ? 5'd7 : 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, d_at, b_cnt, r);
      total++; if (d_at !== 0)          begin bad++; $display("FAIL bypass_latency[%0d]: got %0d want 0", o, d_at); end
      total++; if (b_cnt !== 0)         begin bad++; $display("FAIL bypass_busy[%0d]: got %0d want 0", o, b_cnt); end
      total++; if (r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_result[%0d]: got %h want deadbeef", o, r); end
    end
  endtask

  task automatic test_start_mid_shift();
    int d_at; logic [31:0] r;
    @(negedge clk); start = 1'b1; op = 2'b00; shamt = 5'd3; data_in = 32'h1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); start = 1'b1; shamt = 5'd5; data_in = 32'hFFFF;
    @(posedge clk); #1; start = 1'b0;
    d_at = -1; r = 'x;
    for (int n = 1; n < 20; n++) begin
      @(negedge clk);
      if (done) begin d_at = n; r = result; break; end
    end
    total++; if (d_at !== 3)   begin bad++; $display("FAIL midstart_latency: got %0d want 3", d_at); end
    total++; if (r !== 32'h8)  begin bad++; $display("FAIL midstart_result: got %h want 00000008", r); end
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midstart_idle: got %b want 00", {busy, done}); end
  endtask

  task automatic test_back_to_back();
    int d_at;
    @(negedge clk); start = 1'b1; op = 2'b01; shamt = 5'd2; data_in = 32'hF0;
    @(posedge clk); #1; start = 1'b0;
    d_at = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) begin d_at = n; break; end
    end
    total++; if (d_at !== 2)       begin bad++; $display("FAIL b2b_first_latency: got %0d want 2", d_at); end
    total++; if (result !== 32'h3C) begin bad++; $display("FAIL b2b_first_result: got %h want 0000003c", result); end
    start = 1'b1; op = 2'b00; shamt = 5'd1; data_in = 32'h3;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_no_idle: got %b want 10", {busy, done}); end
    @(negedge clk);
    total++; if (done !== 1'b1)    begin bad++; $display("FAIL b2b_second_done: got %b want 1", done); end
    total++; if (result !== 32'h6) begin bad++; $display("FAIL b2b_second_result: got %h want 00000006", result); end
  endtask

  task automatic test_abort();
    int pulses;
    @(negedge clk); start = 1'b1; op = 2'b01; shamt = 5'd10; data_in = 32'hFFFF_0000;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL abort_state: got %b want 00", {busy, done}); end
    total++; if (result !== 32'h0)       begin bad++; $display("FAIL abort_result: got %h want 0", result); end
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_abort_with_start();
    int d_at, b_cnt; logic [31:0] r;
    run_op(2'b00, 5'd1, 32'h1, 1'b0, 1'b0, d_at, b_cnt, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL abst_pre_result: got %h want 00000002", r); end
    @(negedge clk); start = 1'b1; op = 2'b00; shamt = 5'd5; data_in = 32'h1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); @(negedge clk);
    abort = 1'b1; start = 1'b1; shamt = 5'd2; data_in = 32'h7;
    @(posedge clk); #1; abort = 1'b0; start = 1'b0;
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL abst_state: got %b want 00", {busy, done}); end
    total++; if (result !== 32'h0)       begin bad++; $display("FAIL abst_result: got %h want 0", result); end
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL abst_start_dropped: got %b want 00", {busy, done}); end
  endtask

  task automatic test_abort_idle();
    int d_at, b_cnt; logic [31:0] r;
    run_op(2'b00, 5'd2, 32'h1, 1'b0, 1'b1, d_at, b_cnt, r);
    total++; if (d_at !== 2)  begin bad++; $display("FAIL idle_abort_latency: got %0d want 2", d_at); end
    total++; if (b_cnt !== 2) begin bad++; $display("FAIL idle_abort_busy: got %0d want 2", b_cnt); end
    total++; if (r !== 32'h4) begin bad++; $display("FAIL idle_abort_result: got %h want 00000004", r); end
  endtask

  task automatic test_reset_mid_shift();
    int d_at, b_cnt; logic [31:0] r;
    @(negedge clk); start = 1'b1; op = 2'b00; shamt = 5'd20; data_in = 32'h1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2; rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL rstmid_done: got %b want 0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL rstmid_result: got %h want 0", result); end
    @(negedge clk); rst_n = 1'b1;
    run_op(2'b00, 5'd1, 32'h2, 1'b0, 1'b0, d_at, b_cnt, r);
    total++; if (d_at !== 1)  begin bad++; $display("FAIL rstmid_after_latency: got %0d want 1", d_at); end
    total++; if (r !== 32'h4) begin bad++; $display("FAIL rstmid_after_result: got %h want 00000004", r); end
  endtask

  task automatic test_random();
    int d_at, b_cnt; logic [31:0] r;
    logic [1:0] o; logic [4:0] s; logic [31:0] d;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      s = 5'($urandom);
      d = $urandom;
      run_op(o, s, d, 1'b1, 1'b0, d_at, b_cnt, r);
      total++;
      if ((d_at !== ref_cycles(o, s)) || (b_cnt !== ref_cycles(o, s)) || (r !== ref_shift(o, s, d))) begin
        bad++;
        $display("FAIL random[%0d] op=%0d shamt=%0d data=%h: got lat=%0d busy=%0d res=%h want lat=%0d busy=%0d res=%h",
                 i, o, s, d, d_at, b_cnt, r, ref_cycles(o, s), ref_cycles(o, s), ref_shift(o, s, d));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sll_basic();
    test_sra_srl_31();
    test_bypass();
    test_start_mid_shift();
    test_back_to_back();
    test_abort();
    test_abort_with_start();
    test_abort_idle();
    test_reset_mid_shift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: DATA_W, default 32, datapath width.
REQ-002 Parameter: SHAMT_W, default 5, shift-amount width (log2 DATA_W).
REQ-003 Port: Clk  input  1  single system clock, rising-edge.
REQ-004 Port: Rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: Start  input  1  request pulse, sampled at rising Clk edge.
REQ-006 Port: Op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-007 Port: Shamt  input  SHAMT_W  shift amount, unsigned.
REQ-008 Port: DataIn  input  DATA_W  operand to shift.
REQ-009 Port: Abort  input  1  synchronous cancel of an in-flight shift.
REQ-010 Port: Busy  output  1  high while shifting; new Start ignored.
REQ-011 Port: Done  output  1  one-cycle completion pulse.
REQ-012 Port: Result  output  DATA_W  shifted value, valid when Done is high, held until next accepted Start.

Function
REQ-013 The block SHALL implement states IDLE, SHIFT and DONE; Busy SHALL equal (state==SHIFT) and Done SHALL equal (state==DONE).
REQ-014 A Start SHALL be accepted only in IDLE or DONE; accepting it latches Op, Shamt and DataIn, and loads the working register with DataIn and the counter with Shamt.
REQ-015 On acceptance with Shamt==0 or Op==11, the next state SHALL be DONE with Result=DataIn.
REQ-016 On acceptance with Shamt>0 and Op!=11, the next state SHALL be SHIFT.
REQ-017 Each Clk edge in SHIFT SHALL shift the working register by exactly one bit and decrement the counter; the transition to DONE SHALL occur on the edge where the counter goes from 1 to 0.
REQ-018 Latency: Done SHALL be high in the cycle that follows edge k+Shamt, where k is the edge at which Start was accepted (Shamt+1 cycles counting the Start cycle).
REQ-019 SLL SHALL fill with 0 at the LSB; SRL SHALL fill with 0 at the MSB; SRA SHALL replicate the latched bit DATA_W-1.
REQ-020 DONE SHALL return to IDLE on the next edge unless Start is high, in which case the new request SHALL be accepted, giving back-to-back operation with no idle cycle.
REQ-021 Start while in SHIFT SHALL be ignored without side effects; the in-flight operation SHALL not be disturbed.
REQ-022 Abort high in SHIFT SHALL force IDLE on the next edge with Result=0 and no Done pulse.
REQ-023 If Start and Abort are both high in SHIFT, Abort SHALL win and Start SHALL be dropped.
REQ-024 Abort in IDLE or DONE SHALL have no effect; Start in the same cycle SHALL still be accepted.
REQ-025 Changes on DataIn, Op or Shamt after acceptance SHALL not affect the in-flight result.

Reset
REQ-026 Rst_n low SHALL immediately force state IDLE, Busy=0, Done=0, Result=0, counter=0 and working register=0, regardless of Clk.
REQ-027 Reset asserted mid-shift SHALL discard the operation; after Rst_n rises, the first Start SHALL behave as from power-up.

Structure
REQ-028 A shared package SHALL hold the Op encodings (OP_SLL, OP_SRL, OP_SRA, OP_RSVD), the state encoding (IDLE, SHIFT, DONE) and the DATA_W and SHAMT_W defaults.
REQ-029 The one-bit combinational shift (value, op) -> value SHALL be a sub-module named shift_step, instantiated once.
REQ-030 The FSM, counter and working register SHALL reside in shift_sequencer; there SHALL be no combinational path from Start to Busy, Done or Result.

Verification
REQ-031 SLL, DataIn=0x00000001, Shamt=4 -> Busy for 4 cycles, Done in cycle 5, Result=0x00000010.
REQ-032 SRA, DataIn=0x80000000, Shamt=31 -> Done 32 cycles after the Start cycle, Result=0xFFFFFFFF; same stimulus with SRL -> Result=0x00000001.
REQ-033 Shamt=0, DataIn=0xDEADBEEF, any Op; and Op=11, Shamt=7 -> Done in the next cycle, Result=0xDEADBEEF, Busy never high.
REQ-034 SLL Shamt=3 on 0x1, Start pulsed again mid-shift with DataIn=0xFFFF -> Result=0x8 only; Start held high in the DONE cycle -> second operation begins with no IDLE cycle.
REQ-035 SRL Shamt=10 on 0xFFFF0000, Abort asserted on the 3rd SHIFT cycle -> IDLE next edge, Result=0, Done never pulses.
REQ-036 Rst_n pulsed low between edges mid-shift -> Busy=0 and Result=0 immediately; a following SLL Shamt=1 on 0x2 -> Result=0x4.
